// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the uart_port transmitter,
// receiver and receive buffer.
package uart_pkg;

  // Serial frame phases; both the TX and RX FSMs walk through these.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO for the receive path.
// dout presents the head entry combinationally (0 when empty); a pop takes
// effect at the end of the cycle it is asserted. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  // Pointer width stays at least one bit so a depth-1 buffer still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [2**PW];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Wrap explicitly at DEPTH-1 so a depth of 1 never addresses a spare slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_port.sv
// uart_port: 8N1 UART transceiver for the CPU I/O port.
// Build option: define UART_RX_FIFO_EN for an RX_DEPTH-entry receive FIFO;
// without it the receive buffer is a single holding register.
//
// Handshakes: uart0_wr is a one-cycle strobe accepted only while
// tx_ready=1 (otherwise dropped). uart0_rd pops the show-ahead head when
// rx_valid=1; the popped byte is the one on uart0_data during that cycle.
module uart_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 417,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart0_wr,
  input  logic [7:0]  uart_w,
  input  logic        uart0_rd,
  output logic [7:0]  uart0_data,
  output logic        rx_valid,
  output logic        tx_ready,
  output logic        rx_overrun,
  output logic        rx_ferr,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output uart_state_t tx_state,
  output uart_state_t rx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_FIFO_EN
  localparam int FIFO_DEPTH = RX_DEPTH;
`else
  // Holding-register build: RX_DEPTH has no effect on the buffer size.
  localparam int FIFO_DEPTH = (RX_DEPTH > 0) ? 1 : 1;
`endif

  // ---------------- transmitter ----------------
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;

  // TX FSM: shifts the latched byte out LSB first, one bit per baud period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_txd <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (uart0_wr) begin
            tx_sh    <= uart_w;
            tx_cnt   <= '0;
            uart_txd <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_txd <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_txd <= tx_sh[0];
              tx_sh    <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]       rx_sync;
  logic             rxd_s;
  logic             rx_fall;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_stop_sample;
  logic             rx_push;
  logic             rx_ferr_evt;
  logic             rx_overrun_evt;
  logic             fifo_empty;
  logic             fifo_full;

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], uart_rxd};
  end

  assign rxd_s   = rx_sync[1];
  // Falling edge seen one stage early so the start search begins promptly.
  assign rx_fall = rx_sync[1] & ~rx_sync[0];

  assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == BIT_LAST);
  assign rx_push        = rx_stop_sample && rxd_s;
  assign rx_ferr_evt    = rx_stop_sample && !rxd_s;
  // When full, the head is valid, so uart0_rd is guaranteed to free a slot.
  assign rx_overrun_evt = rx_push && fifo_full && !uart0_rd;

  // RX FSM: validates the start bit at half a bit, then samples bit centres.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rxd_s ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Sticky error flags: any read clears them, a coincident set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      if (rx_overrun_evt)  rx_overrun <= 1'b1;
      else if (uart0_rd)   rx_overrun <= 1'b0;
      if (rx_ferr_evt)     rx_ferr    <= 1'b1;
      else if (uart0_rd)   rx_ferr    <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (uart0_rd),
    .din   (rx_sh),
    .dout  (uart0_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rx_valid = !fifo_empty;

endmodule
